majority_voter_word_monitor: RTL

- Parametrised successor of the single-bit packed K-modular voter: votes a W-bit word across K packed replicas and registers the voted word.
- Adds per-replica health monitoring: saturating mismatch counters, persistent-fault detection and sticky fault flags.
- Adds a global health state machine (OK / DEGRADED / FAIL).
- Sits between triplicated configuration/status registers and their consumers; feeds slow-control status registers.

---
 rtl/majority_voter_pkg.sv | 32 +++
 rtl/majority_voter_word_monitor_replica.sv | 62 ++++++
 rtl/majority_voter_word_monitor.sv | 119 +++++++++++
 3 files changed

// File: rtl/majority_voter_pkg.sv
// rtl/majority_voter_pkg.sv - shared types and helpers for the word majority voter
// Contents:
//   health_state_t  : global health state (OK / DEGRADED / FAIL)
//   MAX_K           : largest supported replica count
//   max_tolerable() : number of faulty replicas the vote can still mask
//   bit_majority()  : majority of the low k bits of a MAX_K-bit vector
package majority_voter_pkg;

    typedef enum logic [1:0] {
        HS_OK       = 2'd0,
        HS_DEGRADED = 2'd1,
        HS_FAIL     = 2'd2
    } health_state_t;

    localparam int MAX_K = 7;

    function automatic int max_tolerable(input int k);
        return (k - 1) / 2;
    endfunction

    // Bits at or above position k are ignored, so callers may pass a
    // zero-extended column of any replica count up to MAX_K.
    function automatic logic bit_majority(input logic [MAX_K-1:0] bits, input int k);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_K; i++) begin
            if (i < k) ones += int'(bits[i]);
        end
        return (ones > (k / 2));
    endfunction

endpackage

// File: rtl/majority_voter_word_monitor_replica.sv
// rtl/majority_voter_word_monitor_replica.sv - per-replica mismatch counters and sticky fault flag
// Module mmr_replica_monitor
//   clk_i, rst_n_i : clock, async active-low reset
//   valid_i        : replicas valid this cycle
//   clr_i          : synchronous clear of counters and fault flag
//   disagree       : this replica differs from the voted word
//   err_cnt        : saturating total mismatch count
//   fault          : sticky persistent-fault flag
//   fault_next     : value fault takes at the next edge (feeds the health FSM)
module mmr_replica_monitor #(
    parameter int CNT_W      = 8,
    parameter int PERSIST_TH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic             clr_i,
    input  logic             disagree,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault,
    output logic             fault_next
);

    localparam logic [7:0] TH = 8'(PERSIST_TH);

    logic [7:0] consec_q;
    logic [7:0] consec_inc;

    assign consec_inc = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;

    // Flag sets on the sample that brings the run length to the threshold.
    always_comb begin
        fault_next = fault;
        if (clr_i) begin
            fault_next = 1'b0;
        end else if (valid_i && disagree && (consec_inc >= TH)) begin
            fault_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt  <= '0;
            consec_q <= '0;
            fault    <= 1'b0;
        end else begin
            fault <= fault_next;
            if (clr_i) begin
                err_cnt  <= '0;
                consec_q <= '0;
            end else if (valid_i) begin
                if (disagree) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    consec_q <= consec_inc;
                end else begin
                    consec_q <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/majority_voter_word_monitor.sv
// rtl/majority_voter_word_monitor.sv - K-replica word voter with per-replica health monitoring
// Ports:
//   clk_i, rst_n_i  : clock, async active-low reset
//   valid_i         : replicas valid this cycle
//   clr_i           : synchronous clear of counters, flags and state
//   input_i         : packed replicas, replica r at [r*W +: W]
//   output_o        : registered voted word
//   valid_o         : valid_i delayed one cycle
//   mismatch_o      : some replica disagreed in the last valid cycle
//   mismatch_vec_o  : per-replica disagreement of the last valid cycle
//   err_cnt_o       : packed per-replica saturating mismatch counts
//   fault_o         : sticky per-replica persistent-fault flags
//   state_o         : health state 0 OK, 1 DEGRADED, 2 FAIL
module majority_voter_word_monitor
    import majority_voter_pkg::*;
#(
    parameter int K_MMR         = 3,
    parameter int W             = 8,
    parameter int CNT_W         = 8,
    parameter int PERSIST_TH    = 4,
    parameter bit G_MISMATCH_EN = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic                   clr_i,
    input  logic [K_MMR*W-1:0]     input_i,
    output logic [W-1:0]           output_o,
    output logic                   valid_o,
    output logic                   mismatch_o,
    output logic [K_MMR-1:0]       mismatch_vec_o,
    output logic [K_MMR*CNT_W-1:0] err_cnt_o,
    output logic [K_MMR-1:0]       fault_o,
    output logic [1:0]             state_o
);

    localparam int MAX_TOL = max_tolerable(K_MMR);

    logic [W-1:0]     voted;
    logic [K_MMR-1:0] disagree;
    logic [K_MMR-1:0] fault_next;
    health_state_t    state_q;
    health_state_t    state_next;

    always_comb begin
        logic [MAX_K-1:0] col;
        voted = '0;
        for (int b = 0; b < W; b++) begin
            col = '0;
            for (int r = 0; r < K_MMR; r++) col[r] = input_i[r*W + b];
            voted[b] = bit_majority(col, K_MMR);
        end
    end

    always_comb begin
        disagree = '0;
        for (int r = 0; r < K_MMR; r++) begin
            disagree[r] = (input_i[r*W +: W] != voted);
        end
    end

    genvar gr;
    generate
        for (gr = 0; gr < K_MMR; gr++) begin : g_mon
            mmr_replica_monitor #(
                .CNT_W      (CNT_W),
                .PERSIST_TH (PERSIST_TH)
            ) u_mon (
                .clk_i      (clk_i),
                .rst_n_i    (rst_n_i),
                .valid_i    (valid_i),
                .clr_i      (clr_i),
                .disagree   (disagree[gr]),
                .err_cnt    (err_cnt_o[gr*CNT_W +: CNT_W]),
                .fault      (fault_o[gr]),
                .fault_next (fault_next[gr])
            );
        end
    endgenerate

    // Health is judged on the fault set the flags are about to hold, so the
    // state moves on the same edge as fault_o.
    always_comb begin
        int f;
        f = 0;
        for (int r = 0; r < K_MMR; r++) f += int'(fault_next[r]);
        if (state_q == HS_FAIL)  state_next = HS_FAIL;
        else if (f == 0)         state_next = HS_OK;
        else if (f <= MAX_TOL)   state_next = HS_DEGRADED;
        else                     state_next = HS_FAIL;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            output_o       <= '0;
            valid_o        <= 1'b0;
            mismatch_o     <= 1'b0;
            mismatch_vec_o <= '0;
            state_q        <= HS_OK;
        end else begin
            valid_o <= valid_i;
            if (valid_i) output_o <= voted;
            if (clr_i) begin
                mismatch_vec_o <= '0;
                mismatch_o     <= 1'b0;
                state_q        <= HS_OK;
            end else begin
                if (valid_i) begin
                    mismatch_vec_o <= disagree;
                    mismatch_o     <= G_MISMATCH_EN ? |disagree : 1'b0;
                end
                state_q <= state_next;
            end
        end
    end

    assign state_o = state_q;

endmodule
